// File: rtl/moore_seq_gen_if.sv
// Symbol bus between the sequence generator and its sink.
// Plain valid/ready handshake carrying one 3-bit symbol per transfer.
interface moore_seq_gen_if;
   logic [2:0] out_sym;
   logic       out_valid;
   logic       out_ready;

   modport master (
      output out_sym,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_sym,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/moore_seq_gen.sv
// Sync-pattern frame generator: LFSR filler then 0,7,0,3, repeated.
// Filler never produces 0, so a downstream detector stays in s0.
module moore_seq_gen #(
   parameter logic [3:0] LFSR_SEED = 4'b1001
) (
   input  logic           clk,
   input  logic           clear,
   input  logic           start,
   input  logic [3:0]     gap,
   input  logic [3:0]     reps,
   moore_seq_gen_if.master bus,
   output logic           busy,
   output logic           done,
   output logic [2:0]     state,
   output logic [7:0]     frames
);

   localparam logic [3:0] SEED =
      (LFSR_SEED == 4'd0) ? 4'b0001 : LFSR_SEED;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      FILL = 3'd1,
      P0   = 3'd2,
      P1   = 3'd3,
      P2   = 3'd4,
      P3   = 3'd5
   } state_t;

   state_t     st;
   logic [3:0] lfsr;
   logic [3:0] gap_lat;
   logic [3:0] gap_cnt;
   logic [3:0] rep_cnt;
   logic       valid;
   logic       xfer;
   logic [2:0] filler;
   logic [2:0] sym;
   logic [3:0] lfsr_next;

   assign xfer      = valid && bus.out_ready;
   assign lfsr_next = {lfsr[2:0], lfsr[3] ^ lfsr[2]};

   // Filler from the LFSR, with pattern-like values folded onto 5.
   always_comb begin
      filler = lfsr[2:0];
      if (filler == 3'd0 || filler == 3'd3 || filler == 3'd7)
         filler = 3'd5;
   end

   // Output symbol decoded from the registered state and LFSR.
   always_comb begin
      sym = 3'd1;
      case (st)
         FILL:    sym = filler;
         P0:      sym = 3'd0;
         P1:      sym = 3'd7;
         P2:      sym = 3'd0;
         P3:      sym = 3'd3;
         default: sym = 3'd1;
      endcase
   end

   assign bus.out_sym   = sym;
   assign bus.out_valid = valid;
   assign state         = st;

   // Frame FSM with counters; everything holds while a symbol stalls.
   always_ff @(posedge clk) begin
      if (clear) begin
         st      <= IDLE;
         valid   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         frames  <= 8'd0;
         lfsr    <= SEED;
         gap_lat <= 4'd0;
         gap_cnt <= 4'd0;
         rep_cnt <= 4'd0;
      end else begin
         done <= 1'b0;
         case (st)
            IDLE: begin
               if (start) begin
                  gap_lat <= gap;
                  gap_cnt <= gap;
                  rep_cnt <= (reps == 4'd0) ? 4'd1 : reps;
                  st      <= (gap != 4'd0) ? FILL : P0;
                  valid   <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            FILL: begin
               if (xfer) begin
                  lfsr    <= lfsr_next;
                  gap_cnt <= gap_cnt - 4'd1;
                  if (gap_cnt == 4'd1)
                     st <= P0;
               end
            end
            P0: if (xfer) st <= P1;
            P1: if (xfer) st <= P2;
            P2: if (xfer) st <= P3;
            P3: begin
               if (xfer) begin
                  frames <= frames + 8'd1;
                  if (rep_cnt > 4'd1) begin
                     rep_cnt <= rep_cnt - 4'd1;
                     gap_cnt <= gap_lat;
                     st      <= (gap_lat != 4'd0) ? FILL : P0;
                  end else begin
                     rep_cnt <= 4'd0;
                     st      <= IDLE;
                     valid   <= 1'b0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end
               end
            end
            default: begin
               st    <= IDLE;
               valid <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
